n64_console_poller: RTL and testbench

N64_CONSOLE_POLLER -- requirements
Module: n64_console_poller

---
 rtl/n64_pkg.sv | 26 ++
 rtl/n64_rx_bit_sampler.sv | 63 ++++++
 rtl/n64_console_poller.sv | 161 ++++++++++++++++
 tb/tb_n64_console_poller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_pkg.sv
// Shared definitions for the N64 console-side controller poller: state encoding,
// command/response sizes and the line timing expressed in microseconds.
package n64_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TX_BIT  = 3'd1,
    ST_TX_STOP = 3'd2,
    ST_RX_WAIT = 3'd3,
    ST_RX_BIT  = 3'd4,
    ST_RX_STOP = 3'd5
  } n64_state_t;

  localparam logic [7:0] CMD_POLL  = 8'h01;
  localparam int         CMD_BITS  = 8;
  localparam int         RESP_BITS = 32;

  // Bit cell: 4 us total, low for 3 us (zero) or 1 us (one); stop is 1 us low + 2 us high.
  localparam int BIT_US      = 4;
  localparam int ZERO_LOW_US = 3;
  localparam int ONE_LOW_US  = 1;
  localparam int STOP_LOW_US = 1;
  localparam int STOP_REL_US = 2;
  localparam int SAMPLE_US   = 2;

endpackage

// File: rtl/n64_rx_bit_sampler.sv
// Receive front end: 2-flop synchronizer on the shared data line, falling-edge
// detector, sample-point timer and the response timeout counter.
module n64_rx_bit_sampler
  import n64_pkg::*;
#(
  parameter int CLK_PER_US  = 2,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic sample_clk,
  input  logic rst_n,
  input  logic data_rx,
  input  logic tmo_en,
  input  logic tmo_clr,
  output logic line,
  output logic fall,
  output logic sample_now,
  output logic tmo_hit
);

  localparam int SAMPLE_CYC = SAMPLE_US * CLK_PER_US;
  localparam int SCW        = $clog2(SAMPLE_CYC + 1);
  localparam int TMW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SCW-1:0] SMP_LAST = SCW'(SAMPLE_CYC - 1);
  localparam logic [SCW-1:0] SMP_SAT  = SCW'(SAMPLE_CYC);
  localparam logic [TMW-1:0] TMO_LAST = TMW'(TIMEOUT_CYC - 1);

  logic           sync1;
  logic           sync2;
  logic           line_prev;
  logic [SCW-1:0] smp_cnt;
  logic [TMW-1:0] tmo_cnt;

  assign line       = sync2;
  assign fall       = line_prev & ~sync2;
  assign sample_now = (smp_cnt == SMP_LAST);
  assign tmo_hit    = (tmo_cnt == TMO_LAST);

  always_ff @(posedge sample_clk) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
      smp_cnt   <= '0;
      tmo_cnt   <= '0;
    end else begin
      sync1     <= data_rx;
      sync2     <= sync1;
      line_prev <= sync2;
      // Sample timer restarts on each falling edge and parks one past the sample point.
      if (fall) begin
        smp_cnt <= '0;
      end else if (smp_cnt != SMP_SAT) begin
        smp_cnt <= smp_cnt + SCW'(1);
      end
      if (!tmo_en || tmo_clr || fall) begin
        tmo_cnt <= '0;
      end else if (!tmo_hit) begin
        tmo_cnt <= tmo_cnt + TMW'(1);
      end
    end
  end

endmodule

// File: rtl/n64_console_poller.sv
// Console side of the N64 joybus: sends the 0x01 poll command on an open-drain
// line, receives the 32-bit controller status and presents buttons and stick axes.
module n64_console_poller
  import n64_pkg::*;
#(
  parameter int CLK_PER_US  = 2,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic        sample_clk,
  input  logic        rst_n,
  input  logic        poll_req,
  input  logic        data_rx,
  output logic        data_tx,
  output logic        busy,
  output logic        resp_valid,
  output logic        timeout_err,
  output logic [15:0] button_state,
  output logic [7:0]  joy_x,
  output logic [7:0]  joy_y,
  output logic [2:0]  state_dbg
);

  // Handshake: poll_req is a one-cycle request accepted only while busy=0; each
  // accepted request ends in exactly one resp_valid or one timeout_err pulse.

  localparam int BIT_CYC  = BIT_US * CLK_PER_US;
  localparam int STOP_CYC = (STOP_LOW_US + STOP_REL_US) * CLK_PER_US;
  localparam int TCW      = $clog2(BIT_CYC + 1);
  localparam int RCW      = $clog2(RESP_BITS + 1);
  localparam logic [TCW-1:0] BIT_LAST   = TCW'(BIT_CYC - 1);
  localparam logic [TCW-1:0] STOP_LAST  = TCW'(STOP_CYC - 1);
  localparam logic [TCW-1:0] ZERO_LOW_V = TCW'(ZERO_LOW_US * CLK_PER_US);
  localparam logic [TCW-1:0] ONE_LOW_V  = TCW'(ONE_LOW_US * CLK_PER_US);
  localparam logic [TCW-1:0] STOP_LOW_V = TCW'(STOP_LOW_US * CLK_PER_US);
  localparam logic [RCW-1:0] RX_FULL    = RCW'(RESP_BITS);
  localparam logic [2:0]     CMD_LAST   = 3'(CMD_BITS - 1);

  n64_state_t           state;
  logic [TCW-1:0]       tx_cnt;
  logic [TCW-1:0]       tx_cnt_inc;
  logic [2:0]           tx_idx;
  logic [TCW-1:0]       low_len;
  logic [RCW-1:0]       rx_cnt;
  logic [RESP_BITS-1:0] shift_q;
  logic                 line;
  logic                 fall;
  logic                 sample_now;
  logic                 tmo_hit;
  logic                 tmo_en;
  logic                 tmo_clr;

  assign busy       = (state != ST_IDLE);
  assign state_dbg  = state;
  assign tx_cnt_inc = tx_cnt + TCW'(1);
  assign low_len    = CMD_POLL[CMD_LAST - tx_idx] ? ONE_LOW_V : ZERO_LOW_V;
  assign tmo_en     = (state inside {ST_RX_WAIT, ST_RX_BIT, ST_RX_STOP});
  assign tmo_clr    = (state == ST_RX_BIT) && sample_now;

  n64_rx_bit_sampler #(
    .CLK_PER_US (CLK_PER_US),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_sampler (
    .sample_clk(sample_clk),
    .rst_n     (rst_n),
    .data_rx   (data_rx),
    .tmo_en    (tmo_en),
    .tmo_clr   (tmo_clr),
    .line      (line),
    .fall      (fall),
    .sample_now(sample_now),
    .tmo_hit   (tmo_hit)
  );

  always_ff @(posedge sample_clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      tx_cnt       <= '0;
      tx_idx       <= '0;
      rx_cnt       <= '0;
      shift_q      <= '0;
      data_tx      <= 1'b0;
      resp_valid   <= 1'b0;
      timeout_err  <= 1'b0;
      button_state <= '0;
      joy_x        <= '0;
      joy_y        <= '0;
    end else begin
      resp_valid  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A line held low by someone else means the bus is not ours to drive.
          if (poll_req && line) begin
            state   <= ST_TX_BIT;
            tx_cnt  <= '0;
            tx_idx  <= '0;
            rx_cnt  <= '0;
            shift_q <= '0;
            data_tx <= 1'b1;
          end
        end
        ST_TX_BIT: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt  <= '0;
            data_tx <= 1'b1;
            if (tx_idx == CMD_LAST) begin
              state <= ST_TX_STOP;
            end else begin
              tx_idx <= tx_idx + 3'd1;
            end
          end else begin
            tx_cnt  <= tx_cnt_inc;
            data_tx <= (tx_cnt_inc < low_len);
          end
        end
        ST_TX_STOP: begin
          if (tx_cnt == STOP_LAST) begin
            tx_cnt  <= '0;
            data_tx <= 1'b0;
            state   <= ST_RX_WAIT;
          end else begin
            tx_cnt  <= tx_cnt_inc;
            data_tx <= (tx_cnt_inc < STOP_LOW_V);
          end
        end
        ST_RX_WAIT: begin
          if (fall) begin
            state <= (rx_cnt == RX_FULL) ? ST_RX_STOP : ST_RX_BIT;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_RX_BIT: begin
          if (sample_now) begin
            shift_q <= {shift_q[RESP_BITS-2:0], line};
            rx_cnt  <= rx_cnt + RCW'(1);
            state   <= ST_RX_WAIT;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_RX_STOP: begin
          if (line) begin
            button_state <= shift_q[31:16];
            joy_x        <= shift_q[15:8];
            joy_y        <= shift_q[7:0];
            resp_valid   <= 1'b1;
            state        <= ST_IDLE;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_console_poller.sv
// Bench for n64_console_poller: open-drain bus model, joybus controller reply
// driver, response scoreboard and cycle-level command waveform reference.
module tb_n64_console_poller;

  localparam int CPU         = 2;
  localparam int TIMEOUT_CYC = 200;
  localparam int BIT_CYC     = 4 * CPU;

  logic        clk;
  logic        rst_n;
  logic        poll_req;
  logic        data_tx;
  logic        busy;
  logic        resp_valid;
  logic        timeout_err;
  logic [15:0] button_state;
  logic [7:0]  joy_x;
  logic [7:0]  joy_y;
  logic [2:0]  state_dbg;
  logic        ctrl_low;
  logic        data_rx;

  // Wired-AND bus: either side pulling low wins.
  assign data_rx = ~(data_tx | ctrl_low);

  n64_console_poller #(
    .CLK_PER_US (CPU),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .sample_clk  (clk),
    .rst_n       (rst_n),
    .poll_req    (poll_req),
    .data_rx     (data_rx),
    .data_tx     (data_tx),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .timeout_err (timeout_err),
    .button_state(button_state),
    .joy_x       (joy_x),
    .joy_y       (joy_y),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          exp_tx[$];
  logic [31:0] exp_q[$];
  logic [31:0] model_word;
  logic [31:0] mon_e;
  int          resp_seen = 0;
  int          tmo_seen  = 0;
  bit          spam_en   = 1'b0;

  function automatic void build_tx_wave();
    logic [7:0] cmd;
    int         low;
    cmd = 8'h01;
    exp_tx.delete();
    for (int b = 7; b >= 0; b--) begin
      low = cmd[b] ? 1 * CPU : 3 * CPU;
      for (int c = 0; c < BIT_CYC; c++) exp_tx.push_back(c < low);
    end
    for (int c = 0; c < 3 * CPU; c++) exp_tx.push_back(c < 1 * CPU);
  endfunction

  // Scoreboard: every response pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (resp_valid || timeout_err) check("excl", 32'(resp_valid & timeout_err), 32'd0);
    if (resp_valid) begin
      resp_seen++;
      if (exp_q.size() == 0) begin
        check("resp_unexp", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_data", {button_state, joy_x, joy_y}, mon_e);
      end
    end
    if (timeout_err) tmo_seen++;
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(negedge clk);
    poll_req = spam_en && ($urandom_range(0, 2) == 0);
  endtask

  task automatic send_bit(input bit v, input int gap);
    int low;
    low = v ? 1 * CPU : 3 * CPU;
    ctrl_low = 1'b1;
    repeat (low) tick();
    ctrl_low = 1'b0;
    repeat (BIT_CYC - low + gap) tick();
  endtask

  // One full poll: command waveform check, optional controller reply, outcome check.
  task automatic run_poll(input logic [31:0] word, input int nbits, input bit stop, input bit spam);
    int r0;
    int t0;
    int w;
    r0 = resp_seen;
    t0 = tmo_seen;
    spam_en  = spam;
    poll_req = 1'b1;
    for (int i = 0; i < exp_tx.size(); i++) begin
      tick();
      check("tx_wave", 32'(data_tx), 32'(exp_tx[i]));
      check("tx_busy", 32'(busy), 32'd1);
    end
    tick();
    check("rx_tx_rel", 32'(data_tx), 32'd0);
    check("rx_busy", 32'(busy), 32'd1);
    if (nbits == 0) begin
      w = 1;
      while (!timeout_err && w < TIMEOUT_CYC + 50) begin
        tick();
        w++;
      end
      check("tmo_lat", 32'(w), 32'(TIMEOUT_CYC + 1));
    end else begin
      repeat ($urandom_range(1, 30)) tick();
      for (int b = 0; b < nbits; b++) send_bit(word[31 - b], $urandom_range(0, 3));
      if (stop) begin
        spam_en  = 1'b0;
        poll_req = 1'b0;
        exp_q.push_back(word);
        ctrl_low = 1'b1;
        repeat (CPU) tick();
        ctrl_low = 1'b0;
        w = 0;
        while (busy && w < 40) begin
          tick();
          w++;
        end
      end else begin
        spam_en  = 1'b0;
        poll_req = 1'b0;
        w = 0;
        while (!timeout_err && w < TIMEOUT_CYC + 50) begin
          tick();
          w++;
        end
      end
    end
    repeat (3) tick();
    if (nbits == 32 && stop) begin
      check("resp_cnt", 32'(resp_seen - r0), 32'd1);
      check("tmo_cnt", 32'(tmo_seen - t0), 32'd0);
      model_word = word;
    end else begin
      check("resp_cnt", 32'(resp_seen - r0), 32'd0);
      check("tmo_cnt", 32'(tmo_seen - t0), 32'd1);
    end
    check("end_busy", 32'(busy), 32'd0);
    check("end_data", {button_state, joy_x, joy_y}, model_word);
    check("q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n      = 1'b0;
    poll_req   = 1'b0;
    ctrl_low   = 1'b0;
    model_word = '0;
    build_tx_wave();
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(data_tx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rv", 32'(resp_valid), 32'd0);
    check("rst_te", 32'(timeout_err), 32'd0);
    check("rst_data", {button_state, joy_x, joy_y}, 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Directed reply with known fields.
    run_poll(32'h8000_7F81, 32, 1'b1, 1'b0);
    check("dir_btn", 32'(button_state), 32'h0000_8000);
    check("dir_jx", 32'(joy_x), 32'h0000_007F);
    check("dir_jy", 32'(joy_y), 32'h0000_0081);

    // Poll while a controller holds the line low is dropped.
    ctrl_low = 1'b1;
    repeat (4) tick();
    poll_req = 1'b1;
    repeat (4) tick();
    check("low_busy", 32'(busy), 32'd0);
    ctrl_low = 1'b0;
    repeat (4) tick();

    // No reply, then a reply that stops after 20 bits, then an all-zero reply.
    run_poll($urandom, 0, 1'b0, 1'b0);
    run_poll($urandom, 20, 1'b0, 1'b0);
    run_poll(32'h0000_0000, 32, 1'b1, 1'b0);

    // Repeated poll_req during TX and RX must not start a second transaction.
    run_poll($urandom, 32, 1'b1, 1'b1);

    for (int k = 0; k < 6; k++) begin
      run_poll($urandom, 32, 1'b1, 1'($urandom_range(0, 1)));
    end

    // Reset during bit 3 of the command.
    spam_en  = 1'b0;
    poll_req = 1'b1;
    for (int i = 0; i <= 26; i++) tick();
    check("pre_rst_tx", 32'(data_tx), 32'(exp_tx[26]));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_tx", 32'(data_tx), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", {button_state, joy_x, joy_y}, 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    model_word = '0;
    repeat (4) tick();
    run_poll($urandom, 32, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
